// File: rtl/decoder_pkg.sv
// Shared decode helpers and mode constants for display-select blocks.
// Used by the registered N-to-2^N decoder and other display drivers.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest code onehot_decode supports; callers size-cast the result down.
    localparam int MAX_N = 8;
    localparam int MAX_W = 1 << MAX_N;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Codes at or above 2^n decode to all zeros.
    function automatic logic [MAX_W-1:0] onehot_decode(input logic [MAX_N-1:0] code,
                                                       input int unsigned n);
        logic [MAX_W-1:0] v;
        v = '0;
        if (32'(code) < (32'd1 << n))
            v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_nto2n_prescaler.sv
// Scan prescaler: counts run cycles 0..DIV-1 and flags the last one.
// clear has priority over run; with neither asserted the count holds.
module scan_prescaler
    import decoder_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count_q <= '0;
        else if (run)
            count_q <= (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    assign tick = run && (count_q == LAST);

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct and self-scanning modes.
// y, code and wrap are all flops; y is computed from the next code so it changes with code.
module decoder_scan_nto2n
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter int SCAN_LAST  = (1 << N) - 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      x,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      code,
    output logic              wrap
);

    localparam int W = 1 << N;
    localparam logic [N-1:0] LAST_C   = N'(SCAN_LAST);
    localparam logic [W-1:0] DEASSERT = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    logic [N-1:0] code_q, code_d;
    logic         mode_q, mode_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] y_q, y_d;
    logic         clear, run, tick;
    logic [W-1:0] onehot;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .run   (run),
        .tick  (tick)
    );

    // mode_q only follows mode while enabled, so a pause never looks like a scan entry.
    always_comb begin
        code_d = code_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        clear  = 1'b0;
        run    = 1'b0;
        if (en) begin
            mode_d = mode;
            if (mode == MODE_DIRECT) begin
                code_d = x;
                clear  = 1'b1;
            end else if (mode_q == MODE_DIRECT) begin
                code_d = '0;
                clear  = 1'b1;
            end else begin
                run = 1'b1;
                if (tick) begin
                    if (code_q >= LAST_C) begin
                        code_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        code_d = code_q + N'(1);
                    end
                end
            end
        end
        onehot = W'(onehot_decode(MAX_N'(code_d), N));
        y_d    = en ? (onehot ^ DEASSERT) : DEASSERT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= '0;
            mode_q <= MODE_DIRECT;
            wrap_q <= 1'b0;
            y_q    <= DEASSERT;
        end else begin
            code_q <= code_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            y_q    <= y_d;
        end
    end

    assign y    = y_q;
    assign code = code_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: two configurations driven in lockstep, an
// arithmetic model feeding expected queues, and directed literal checks.
module tb_decoder_scan_nto2n;

    logic       clk = 1'b0;
    logic       reset, en, mode;
    logic [2:0] x;
    logic [7:0] u0_y, u1_y;
    logic [2:0] u0_code, u1_code;
    logic       u0_wrap, u1_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    decoder_scan_nto2n #(.N(3), .DIV(4), .SCAN_LAST(7), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .x(x),
        .y(u0_y), .code(u0_code), .wrap(u0_wrap)
    );

    decoder_scan_nto2n #(.N(3), .DIV(1), .SCAN_LAST(3), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .x(x),
        .y(u1_y), .code(u1_code), .wrap(u1_wrap)
    );

    // model: scan code is derived from run cycles elapsed since scan entry
    int   p_div[2]  = '{4, 1};
    int   p_last[2] = '{7, 3};
    int   p_al[2]   = '{0, 1};
    int   m_code[2], m_t[2];
    bit   m_scan[2], m_en[2], m_wrap[2];
    bit   m_valid = 1'b0;
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

    always @(posedge clk) begin
        bit         live;
        logic [7:0] ye;
        live = m_valid || reset;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_code[i] = 0; m_t[i] = 0; m_scan[i] = 0; m_en[i] = 0; m_wrap[i] = 0;
            end else if (m_valid) begin
                m_wrap[i] = 0;
                m_en[i]   = en;
                if (en) begin
                    if (!mode) begin
                        m_code[i] = int'(x);
                        m_scan[i] = 0;
                    end else if (!m_scan[i]) begin
                        m_scan[i] = 1;
                        m_t[i]    = 0;
                        m_code[i] = 0;
                    end else begin
                        m_t[i]    = m_t[i] + 1;
                        m_code[i] = (m_t[i] / p_div[i]) % (p_last[i] + 1);
                        m_wrap[i] = (m_t[i] % p_div[i] == 0) && (m_code[i] == 0);
                    end
                end
            end
            if (live) begin
                ye = m_en[i] ? 8'(1 << m_code[i]) : 8'h00;
                if (p_al[i] != 0) ye = ~ye;
                if (i == 0) exp_q0.push_back({ye, 3'(m_code[i]), m_wrap[i]});
                else        exp_q1.push_back({ye, 3'(m_code[i]), m_wrap[i]});
            end
        end
        if (reset) m_valid = 1'b1;
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            n_cmp++;
            if ({u0_y, u0_code, u0_wrap} !== e) begin
                n_bad++;
                $display("FAIL model_u0 t=%0t: got y=%h code=%0d wrap=%b, want y=%h code=%0d wrap=%b",
                         $time, u0_y, u0_code, u0_wrap, e[11:4], e[3:1], e[0]);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            n_cmp++;
            if ({u1_y, u1_code, u1_wrap} !== e) begin
                n_bad++;
                $display("FAIL model_u1 t=%0t: got y=%h code=%0d wrap=%b, want y=%h code=%0d wrap=%b",
                         $time, u1_y, u1_code, u1_wrap, e[11:4], e[3:1], e[0]);
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; x = 3'd0;
        tick(2);
        chk("reset_u0_y", 32'(u0_y), 32'h00);
        chk("reset_u0_code", 32'(u0_code), 32'd0);
        chk("reset_u0_wrap", 32'(u0_wrap), 32'd0);
        chk("reset_u1_y", 32'(u1_y), 32'hFF);

        // direct mode, one-clock latency
        reset = 1'b0; en = 1'b1; x = 3'd5;
        tick(1);
        chk("direct5_u0_y", 32'(u0_y), 32'b0010_0000);
        chk("direct5_u0_code", 32'(u0_code), 32'd5);
        chk("direct5_u1_y", 32'(u1_y), 32'b1101_1111);
        for (int i = 0; i < 8; i++) begin
            x = 3'(i);
            tick(1);
        end
        x = 3'd2;
        tick(1);
        chk("direct2_u1_y", 32'(u1_y), 32'b1111_1011);
        en = 1'b0;
        tick(1);
        chk("blank_u1_y", 32'(u1_y), 32'hFF);
        chk("blank_u0_y", 32'(u0_y), 32'h00);
        chk("blank_u0_code", 32'(u0_code), 32'd2);
        en = 1'b1;
        tick(1);

        // scan entry and walk
        mode = 1'b1;
        tick(1);
        chk("entry_u0_code", 32'(u0_code), 32'd0);
        chk("entry_u0_y", 32'(u0_y), 32'h01);
        chk("entry_u0_wrap", 32'(u0_wrap), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (k == 3)  chk("scan_u0_k3_code", 32'(u0_code), 32'd0);
            if (k == 4)  chk("scan_u0_k4_code", 32'(u0_code), 32'd1);
            if (k == 31) chk("scan_u0_k31_code", 32'(u0_code), 32'd7);
            if (k == 31) chk("scan_u0_k31_wrap", 32'(u0_wrap), 32'd0);
            if (k == 32) chk("scan_u0_k32_code", 32'(u0_code), 32'd0);
            if (k == 32) chk("scan_u0_k32_wrap", 32'(u0_wrap), 32'd1);
            if (k == 33) chk("scan_u0_k33_wrap", 32'(u0_wrap), 32'd0);
            if (k == 3)  chk("scan_u1_k3_code", 32'(u1_code), 32'd3);
            if (k == 4)  chk("scan_u1_k4_code", 32'(u1_code), 32'd0);
            if (k == 4)  chk("scan_u1_k4_wrap", 32'(u1_wrap), 32'd1);
            if (k == 5)  chk("scan_u1_k5_y", 32'(u1_y), 32'hFD);
        end

        // pause at code=2, prescaler=1, then resume
        tick(1);
        chk("prepause_u0_code", 32'(u0_code), 32'd2);
        en = 1'b0;
        tick(10);
        chk("pause_u0_y", 32'(u0_y), 32'h00);
        chk("pause_u0_code", 32'(u0_code), 32'd2);
        chk("pause_u1_y", 32'(u1_y), 32'hFF);
        en = 1'b1;
        tick(1);
        chk("resume1_u0_code", 32'(u0_code), 32'd2);
        chk("resume1_u0_y", 32'(u0_y), 32'h04);
        tick(1);
        chk("resume2_u0_code", 32'(u0_code), 32'd2);
        tick(1);
        chk("resume3_u0_code", 32'(u0_code), 32'd3);
        chk("resume3_u0_y", 32'(u0_y), 32'h08);

        // reset mid-scan at code 6, then reset against a scan entry
        tick(12);
        chk("prereset_u0_code", 32'(u0_code), 32'd6);
        reset = 1'b1;
        tick(1);
        chk("midreset_u0_code", 32'(u0_code), 32'd0);
        chk("midreset_u0_y", 32'(u0_y), 32'h00);
        chk("midreset_u0_wrap", 32'(u0_wrap), 32'd0);
        chk("midreset_u1_y", 32'(u1_y), 32'hFF);
        mode = 1'b0;
        tick(1);
        mode = 1'b1;
        tick(1);
        chk("resetwins_u0_y", 32'(u0_y), 32'h00);
        chk("resetwins_u0_code", 32'(u0_code), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("postreset_entry_u0_y", 32'(u0_y), 32'h01);
        chk("postreset_entry_u1_y", 32'(u1_y), 32'hFE);
        tick(3);
        chk("postreset_u0_k3_code", 32'(u0_code), 32'd0);
        tick(1);
        chk("postreset_u0_k4_code", 32'(u0_code), 32'd1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
